seq_add64_ctrl: RTL and testbench

//  Multi-cycle sequencer for wide addition through one narrow adder slice.

---
 rtl/seq_add64_ctrl.sv | 110 +++++++++++
 tb/tb_seq_add64_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_add64_ctrl.sv
// Sequential wide adder: walks a WIDTH-bit A+B+Cin through one SLICE-bit adder,
// LSB slice first, one slice per clock, with the inter-slice carry held in a register.
module seq_add64_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic [1:0]       state_o
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic             carry_out_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [SLICE:0]   slice_res;
  logic             last_slice;
  int               base;

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // start in any other cycle is ignored. done is high for exactly one cycle
  // when Sum/Carry are final, and they hold until the next accepted request.

  always_comb begin
    base       = int'(idx_q) * SLICE;
    slice_res  = {1'b0, a_q[base +: SLICE]} + {1'b0, b_q[base +: SLICE]}
               + {{SLICE{1'b0}}, carry_q};
    sum_d      = sum_q;
    sum_d[base +: SLICE] = slice_res[SLICE-1:0];
    last_slice = (idx_q == IDXW'(NSLICE - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_slice) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready   = (state_q == S_IDLE);
    busy    = (state_q == S_RUN) || (state_q == S_DONE);
    done    = (state_q == S_DONE);
    state_o = state_q;
  end

  // Sum is cleared on accept so unprocessed slices read zero while running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q         <= A;
            b_q         <= B;
            carry_q     <= Cin;
            idx_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
          end
        end
        S_RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_res[SLICE];
          if (last_slice) carry_out_q <= slice_res[SLICE];
          else            idx_q       <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Sum   = sum_q;
  assign Carry = carry_out_q;

endmodule

// File: tb/tb_seq_add64_ctrl.sv
// Bench for seq_add64_ctrl: default 64/16 build plus 32/8 and 16/16 builds,
// expected results queued at issue and checked by monitors on done.
module tb_seq_add64_ctrl;

  logic clk, rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // 64/16 instance
  logic        m_start, m_cin, m_ready, m_busy, m_done, m_carry;
  logic [63:0] m_a, m_b, m_sum;
  logic [1:0]  m_st;
  logic [64:0] m_q[$];
  logic [64:0] m_e;

  // 32/8 instance
  logic        s_start, s_cin, s_ready, s_busy, s_done, s_carry;
  logic [31:0] s_a, s_b, s_sum;
  logic [1:0]  s_st;
  logic [32:0] s_q[$];
  logic [32:0] s_e;

  // 16/16 instance (single slice)
  logic        u_start, u_cin, u_ready, u_busy, u_done, u_carry;
  logic [15:0] u_a, u_b, u_sum;
  logic [1:0]  u_st;
  logic [16:0] u_q[$];
  logic [16:0] u_e;

  seq_add64_ctrl #(.WIDTH(64), .SLICE(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(m_start), .A(m_a), .B(m_b), .Cin(m_cin),
    .ready(m_ready), .busy(m_busy), .done(m_done), .Sum(m_sum), .Carry(m_carry),
    .state_o(m_st)
  );

  seq_add64_ctrl #(.WIDTH(32), .SLICE(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .A(s_a), .B(s_b), .Cin(s_cin),
    .ready(s_ready), .busy(s_busy), .done(s_done), .Sum(s_sum), .Carry(s_carry),
    .state_o(s_st)
  );

  seq_add64_ctrl #(.WIDTH(16), .SLICE(16)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(u_start), .A(u_a), .B(u_b), .Cin(u_cin),
    .ready(u_ready), .busy(u_busy), .done(u_done), .Sum(u_sum), .Carry(u_carry),
    .state_o(u_st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // monitors / scoreboards
  always @(negedge clk) begin
    if (rst_n && m_done) begin
      if (m_q.size() == 0) flag_fail("m_unexpected_done", "done with empty queue");
      else begin
        m_e = m_q.pop_front();
        chk("m_result", {m_carry, m_sum}, m_e);
        chk("m_done_flags", {63'd0, m_ready, m_busy}, 65'b01);
      end
    end
    if (rst_n && s_done) begin
      if (s_q.size() == 0) flag_fail("s_unexpected_done", "done with empty queue");
      else begin
        s_e = s_q.pop_front();
        chk("s_result", {32'd0, s_carry, s_sum}, {32'd0, s_e});
      end
    end
    if (rst_n && u_done) begin
      if (u_q.size() == 0) flag_fail("u_unexpected_done", "done with empty queue");
      else begin
        u_e = u_q.pop_front();
        chk("u_result", {48'd0, u_carry, u_sum}, {48'd0, u_e});
      end
    end
  end

  // driver tasks (called at a negedge, return at the negedge after acceptance)
  task automatic issue_m(input logic [63:0] a, input logic [63:0] b, input logic c,
                         input logic [64:0] exp, input bit push);
    int t = 0;
    while (!m_ready && t < 100) begin @(negedge clk); t++; end
    if (!m_ready) flag_fail("m_issue_timeout", "ready never rose");
    m_start = 1'b1; m_a = a; m_b = b; m_cin = c;
    @(posedge clk);
    if (push) m_q.push_back(exp);
    @(negedge clk);
    m_start = 1'b0;
    m_a = {$urandom, $urandom}; m_b = {$urandom, $urandom}; m_cin = 1'($urandom_range(0, 1));
  endtask

  task automatic issue_s(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic [32:0] exp);
    int t = 0;
    while (!s_ready && t < 100) begin @(negedge clk); t++; end
    if (!s_ready) flag_fail("s_issue_timeout", "ready never rose");
    s_start = 1'b1; s_a = a; s_b = b; s_cin = c;
    @(posedge clk);
    s_q.push_back(exp);
    @(negedge clk);
    s_start = 1'b0; s_a = $urandom; s_b = $urandom;
  endtask

  task automatic issue_u(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [16:0] exp);
    int t = 0;
    while (!u_ready && t < 100) begin @(negedge clk); t++; end
    if (!u_ready) flag_fail("u_issue_timeout", "ready never rose");
    u_start = 1'b1; u_a = a; u_b = b; u_cin = c;
    @(posedge clk);
    u_q.push_back(exp);
    @(negedge clk);
    u_start = 1'b0; u_a = 16'($urandom); u_b = 16'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((m_q.size() + s_q.size() + u_q.size()) != 0 && t < 500) begin
      @(negedge clk); t++;
    end
    if ((m_q.size() + s_q.size() + u_q.size()) != 0)
      flag_fail("drain_timeout", "expected results never arrived");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rc;
    rst_n = 1'b0;
    m_start = 0; m_a = 0; m_b = 0; m_cin = 0;
    s_start = 0; s_a = 0; s_b = 0; s_cin = 0;
    u_start = 0; u_a = 0; u_b = 0; u_cin = 0;

    // 1: reset state
    repeat (2) @(negedge clk);
    chk("reset_flags_m", {62'd0, m_ready, m_busy, m_done}, 65'b100);
    chk("reset_result_m", {m_carry, m_sum}, 65'd0);
    chk("reset_flags_s", {62'd0, s_ready, s_busy, s_done}, 65'b100);
    chk("reset_flags_u", {62'd0, u_ready, u_busy, u_done}, 65'b100);
    rst_n = 1'b1;
    @(negedge clk);

    // 2: inter-slice carry with partial-result and latency checks
    issue_m(64'h0000_0001_0000_FFFF, 64'h1, 1'b0, 65'h0_0000_0001_0001_0000, 1'b1);
    chk("t2_busy", {63'd0, m_ready, m_busy}, 65'b01);
    @(negedge clk);
    chk("t2_after_s0", {m_done, m_sum}, 65'h0);
    @(negedge clk);
    chk("t2_after_s1", {m_done, m_sum}, 65'h0_0000_0000_0001_0000);
    @(negedge clk);
    chk("t2_after_s2", {m_done, m_sum}, 65'h0_0000_0001_0001_0000);
    @(negedge clk);
    chk("t2_done_latency", {64'd0, m_done}, 65'd1);
    drain();

    // 3: full ripple, plus more hand-computed vectors
    issue_m(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 65'h1_0000_0000_0000_0000, 1'b1);
    issue_m(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 65'h1_0000_0000_0000_0000, 1'b1);
    issue_m(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 65'h0_2222_2222_2222_2212, 1'b1);
    issue_m(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b1);
    drain();

    // 4: start held high while busy is ignored
    issue_m(64'h5, 64'h7, 1'b0, 65'hC, 1'b1);
    m_start = 1'b1; m_a = 64'hAAAA; m_b = 64'h5555; m_cin = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_ready_after_done", {64'd0, m_ready}, 65'd1);
    @(posedge clk);
    m_q.push_back(65'hFFFF);
    @(negedge clk);
    m_start = 1'b0;
    drain();

    // 5: reset in second RUN cycle aborts without done
    issue_m(64'h3, 64'h4, 1'b0, 65'h7, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_abort_flags", {62'd0, m_ready, m_busy, m_done}, 65'b100);
    chk("t5_abort_result", {m_carry, m_sum}, 65'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // 6: back-to-back random vectors against A+B+Cin
    for (int i = 0; i < 2000; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom_range(0, 1));
      issue_m(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 65'(rc), 1'b1);
    end
    drain();

    // other builds: 32/8 and single-slice 16/16
    issue_s(32'hFFFF_FFFF, 32'h0, 1'b1, 33'h1_0000_0000);
    issue_s(32'h00FF_00FF, 32'h0001_0001, 1'b0, 33'h0_0100_0100);
    for (int i = 0; i < 150; i++) begin
      ra = 64'($urandom); rb = 64'($urandom); rc = 1'($urandom_range(0, 1));
      issue_s(ra[31:0], rb[31:0], rc, {1'b0, ra[31:0]} + {1'b0, rb[31:0]} + 33'(rc));
    end
    issue_u(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
    issue_u(16'h1234, 16'h4321, 1'b0, 17'h0_5555);
    for (int i = 0; i < 150; i++) begin
      ra = 64'($urandom); rb = 64'($urandom); rc = 1'($urandom_range(0, 1));
      issue_u(ra[15:0], rb[15:0], rc, {1'b0, ra[15:0]} + {1'b0, rb[15:0]} + 17'(rc));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
